hart_quantum_arbiter: RTL and testbench

//  Time-slice arbiter granting one of N_HARTS cores ownership of the shared interconnect/MMU path.

---
 rtl/hart_quantum_arbiter.sv | 162 ++++++++++++++++
 tb/tb_hart_quantum_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hart_quantum_arbiter.sv
// Time-slice arbiter for the shared interconnect/MMU path of a hart cluster.
// One hart owns the path at a time. Ownership moves on quantum expiry, when
// the owner parks in WFI, or when another hart has an interrupt pending and
// the owner does not. Every handover drains the shared path first and then
// takes one GRANT cycle. During that cycle the new owner index is already
// visible on o_sel and o_switch pulses.
module hart_quantum_arbiter #(
  parameter int N_HARTS     = 2,
  parameter int QUANTUM     = 64,
  parameter bit IRQ_PREEMPT = 1'b1,
  parameter bit IDLE_SKIP   = 1'b1,
  localparam int SELW       = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               i_hold,
  input  logic               i_safe,
  input  logic               i_retire,
  input  logic [N_HARTS-1:0] i_runnable,
  input  logic [N_HARTS-1:0] i_irq,
  input  logic               i_ic_busy,
  input  logic               i_drained,
  output logic [SELW-1:0]    o_sel,
  output logic [N_HARTS-1:0] o_sel_oh,
  output logic [N_HARTS-1:0] o_busy,
  output logic               o_switch,
  output logic [15:0]        o_quantum
);

  // The per-hart vectors are padded to a power of two so that a SELW-bit
  // index always addresses them exactly. Only indices below N_HARTS are
  // ever selected.
  localparam int          NP   = 1 << SELW;
  localparam logic [15:0] QMAX = 16'(QUANTUM);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_GRANT} state_t;

  state_t          state, state_nxt;
  logic [SELW-1:0] sel, next_sel, cand;
  logic [15:0]     count;
  logic            cand_valid, want_switch, take, grant_go;
  logic [NP-1:0]   run_p, irq_p;

  // Retirement counter that stops at QUANTUM. An expired slice stays
  // expired until the next grant.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == QMAX) ? c : c + 16'd1;
  endfunction

  function automatic logic [N_HARTS-1:0] onehot(input logic [SELW-1:0] s);
    return N_HARTS'(1) << s;
  endfunction

  // Effective runnable/irq vectors (WFI is ignored entirely without IDLE_SKIP)
  always_comb begin
    run_p = '0;
    irq_p = '0;
    run_p[N_HARTS-1:0] = i_runnable | {N_HARTS{!IDLE_SKIP}};
    irq_p[N_HARTS-1:0] = i_irq;
  end

  // Candidate search: rotate from the hart after the owner, owner excluded
  always_comb begin
    int              j;
    logic [SELW-1:0] idx;
    j          = 0;
    idx        = '0;
    cand       = '0;
    cand_valid = 1'b0;
    if (IRQ_PREEMPT) begin
      for (int k = 1; k < N_HARTS; k++) begin
        j = int'(sel) + k;
        if (j >= N_HARTS) j = j - N_HARTS;
        idx = SELW'(j);
        if (!cand_valid && irq_p[idx] && run_p[idx]) begin
          cand       = idx;
          cand_valid = 1'b1;
        end
      end
    end
    for (int k = 1; k < N_HARTS; k++) begin
      j = int'(sel) + k;
      if (j >= N_HARTS) j = j - N_HARTS;
      idx = SELW'(j);
      if (!cand_valid && run_p[idx]) begin
        cand       = idx;
        cand_valid = 1'b1;
      end
    end
  end

  // Reasons to give up the path: slice used up, owner asleep, or an
  // interrupted candidate while the owner itself has no interrupt
  always_comb begin
    want_switch = cand_valid &&
                  ((count == QMAX) ||
                   (IDLE_SKIP && !run_p[sel]) ||
                   (IRQ_PREEMPT && !irq_p[sel] && irq_p[cand] && run_p[cand]));
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // FSM next state and stall/switch outputs
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    grant_go  = 1'b0;
    o_busy    = '1;
    o_switch  = 1'b0;
    case (state)
      ST_RUN: begin
        o_busy = ~o_sel_oh | {N_HARTS{i_ic_busy}};
        if (want_switch && i_safe && !i_hold) begin
          take      = 1'b1;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_drained && !i_hold) begin
          grant_go  = 1'b1;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        o_switch  = 1'b1;
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Ownership. The target is frozen at drain entry, and the new owner is
  // installed as GRANT begins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sel      <= '0;
      next_sel <= '0;
      o_sel_oh <= N_HARTS'(1);
    end else begin
      if (take) next_sel <= cand;
      if (grant_go) begin
        sel      <= next_sel;
        o_sel_oh <= onehot(next_sel);
      end
    end
  end

  // Retirement counter. It counts only while running and restarts with each new owner.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                            count <= '0;
    else if (grant_go)                  count <= '0;
    else if (state == ST_RUN && i_retire) count <= sat_inc(count);
  end

  assign o_sel     = sel;
  assign o_quantum = QMAX - count;

endmodule

// File: tb/tb_hart_quantum_arbiter.sv
// Bench for hart_quantum_arbiter. Four configurations run side by side, with
// shared scalar inputs and per-instance hart vectors. A behavioural model is
// kept for each configuration.
module tb_hart_quantum_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic hold, safe, retire, ic_busy, drained;
  logic [3:0] run_a, irq_a;
  logic [2:0] run_b, irq_b;
  logic [0:0] run_c, irq_c;
  logic [1:0] run_d, irq_d;

  logic [1:0] sel_a;  logic [3:0] oh_a, busy_a;  logic sw_a;  logic [15:0] q_a;
  logic [1:0] sel_b;  logic [2:0] oh_b, busy_b;  logic sw_b;  logic [15:0] q_b;
  logic [0:0] sel_c;  logic [0:0] oh_c, busy_c;  logic sw_c;  logic [15:0] q_c;
  logic [0:0] sel_d;  logic [1:0] oh_d, busy_d;  logic sw_d;  logic [15:0] q_d;

  // a: 4 harts, preempt+skip; b: 3 harts, no preempt; c: single hart; d: 2 harts, no skip
  hart_quantum_arbiter #(.N_HARTS(4), .QUANTUM(4), .IRQ_PREEMPT(1'b1), .IDLE_SKIP(1'b1)) u_a (
    .CLK(CLK), .RST(RST), .i_hold(hold), .i_safe(safe), .i_retire(retire),
    .i_runnable(run_a), .i_irq(irq_a), .i_ic_busy(ic_busy), .i_drained(drained),
    .o_sel(sel_a), .o_sel_oh(oh_a), .o_busy(busy_a), .o_switch(sw_a), .o_quantum(q_a));
  hart_quantum_arbiter #(.N_HARTS(3), .QUANTUM(4), .IRQ_PREEMPT(1'b0), .IDLE_SKIP(1'b1)) u_b (
    .CLK(CLK), .RST(RST), .i_hold(hold), .i_safe(safe), .i_retire(retire),
    .i_runnable(run_b), .i_irq(irq_b), .i_ic_busy(ic_busy), .i_drained(drained),
    .o_sel(sel_b), .o_sel_oh(oh_b), .o_busy(busy_b), .o_switch(sw_b), .o_quantum(q_b));
  hart_quantum_arbiter #(.N_HARTS(1), .QUANTUM(8), .IRQ_PREEMPT(1'b1), .IDLE_SKIP(1'b1)) u_c (
    .CLK(CLK), .RST(RST), .i_hold(hold), .i_safe(safe), .i_retire(retire),
    .i_runnable(run_c), .i_irq(irq_c), .i_ic_busy(ic_busy), .i_drained(drained),
    .o_sel(sel_c), .o_sel_oh(oh_c), .o_busy(busy_c), .o_switch(sw_c), .o_quantum(q_c));
  hart_quantum_arbiter #(.N_HARTS(2), .QUANTUM(4), .IRQ_PREEMPT(1'b1), .IDLE_SKIP(1'b0)) u_d (
    .CLK(CLK), .RST(RST), .i_hold(hold), .i_safe(safe), .i_retire(retire),
    .i_runnable(run_d), .i_irq(irq_d), .i_ic_busy(ic_busy), .i_drained(drained),
    .o_sel(sel_d), .o_sel_oh(oh_d), .o_busy(busy_d), .o_switch(sw_d), .o_quantum(q_d));

  // Model: owner, retirements used, pending handover target (-1 none),
  // and whether the owner was installed on the last edge.
  typedef struct {
    int owner;
    int used;
    int target;
    bit fresh;
  } mdl_t;

  mdl_t m_a, m_b, m_c, m_d;
  int nerr = 0;
  int nchk = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.owner = 0; m.used = 0; m.target = -1; m.fresh = 1'b0;
    return m;
  endfunction

  function automatic bit bit_of(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  // Next hart after the owner in rotating order, interrupted ones first
  function automatic int pick(input int n, input bit irqp, input bit idle, input int owner,
                              input logic [3:0] run, input logic [3:0] irq);
    logic [3:0] r;
    r = idle ? run : 4'b1111;
    if (irqp)
      for (int k = 1; k < n; k++)
        if (bit_of(irq, (owner + k) % n) && bit_of(r, (owner + k) % n)) return (owner + k) % n;
    for (int k = 1; k < n; k++)
      if (bit_of(r, (owner + k) % n)) return (owner + k) % n;
    return -1;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t mi, input int n, input int q, input bit irqp,
                                    input bit idle, input logic [3:0] run, input logic [3:0] irq);
    mdl_t m;
    int c;
    logic [3:0] r;
    bit reason;
    m = mi;
    r = idle ? run : 4'b1111;
    if (m.fresh) begin
      m.fresh = 1'b0;
    end else if (m.target >= 0) begin
      if (drained && !hold) begin
        m.owner = m.target; m.used = 0; m.target = -1; m.fresh = 1'b1;
      end
    end else begin
      c = pick(n, irqp, idle, m.owner, run, irq);
      reason = (m.used == q) || (idle && !bit_of(run, m.owner)) ||
               (c >= 0 && irqp && !bit_of(irq, m.owner) && bit_of(irq, c) && bit_of(r, c));
      if (c >= 0 && reason && safe && !hold) m.target = c;
      if (retire && m.used < q) m.used = m.used + 1;
    end
    return m;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input string tag, input mdl_t m, input int n, input int q,
                         input int sel, input int oh, input int busy, input int sw, input int quan);
    int mask;
    int eb;
    mask = (1 << n) - 1;
    if (m.target < 0 && !m.fresh) eb = (mask & ~(1 << m.owner)) | (int'(ic_busy) << m.owner);
    else                          eb = mask;
    chk({tag, ".sel"}, sel, m.owner);
    chk({tag, ".sel_oh"}, oh, 1 << m.owner);
    chk({tag, ".busy"}, busy, eb);
    chk({tag, ".switch"}, sw, int'(m.fresh));
    chk({tag, ".quantum"}, quan, q - m.used);
  endtask

  task automatic check_all();
    chk_dut("a", m_a, 4, 4, int'(sel_a), int'(oh_a), int'(busy_a), int'(sw_a), int'(q_a));
    chk_dut("b", m_b, 3, 4, int'(sel_b), int'(oh_b), int'(busy_b), int'(sw_b), int'(q_b));
    chk_dut("c", m_c, 1, 8, int'(sel_c), int'(oh_c), int'(busy_c), int'(sw_c), int'(q_c));
    chk_dut("d", m_d, 2, 4, int'(sel_d), int'(oh_d), int'(busy_d), int'(sw_d), int'(q_d));
  endtask

  task automatic reset_models();
    m_a = mdl_reset(); m_b = mdl_reset(); m_c = mdl_reset(); m_d = mdl_reset();
  endtask

  // One clock: check at the falling edge, advance the models at the rising edge
  task automatic cycle();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    m_a = mdl_step(m_a, 4, 4, 1'b1, 1'b1, run_a, irq_a);
    m_b = mdl_step(m_b, 3, 4, 1'b0, 1'b1, {1'b0, run_b}, {1'b0, irq_b});
    m_c = mdl_step(m_c, 1, 8, 1'b1, 1'b1, {3'b000, run_c}, {3'b000, irq_c});
    m_d = mdl_step(m_d, 2, 4, 1'b1, 1'b0, {2'b00, run_d}, {2'b00, irq_d});
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic defaults();
    hold = 1'b0; safe = 1'b1; retire = 1'b0; ic_busy = 1'b0; drained = 1'b1;
    run_a = '1; run_b = '1; run_c = '1; run_d = '1;
    irq_a = '0; irq_b = '0; irq_c = '0; irq_d = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    reset_models();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  typedef struct {
    logic retire;
    logic ic_busy;
    int   sel;
    int   sw;
    int   quan;
    int   busy;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int  cyc;
    bit  seen;
    bit  any_sw_c;
    logic [3:0] rv;

    // Two harts, quantum 4, always safe and drained: one full handover
    tbl[0]  = '{1'b1, 1'b0, 0, 0, 4, 2};
    tbl[1]  = '{1'b1, 1'b1, 0, 0, 3, 3};
    tbl[2]  = '{1'b1, 1'b0, 0, 0, 2, 2};
    tbl[3]  = '{1'b1, 1'b0, 0, 0, 1, 2};
    tbl[4]  = '{1'b1, 1'b0, 0, 0, 0, 2};
    tbl[5]  = '{1'b1, 1'b0, 0, 0, 0, 3};
    tbl[6]  = '{1'b1, 1'b0, 1, 1, 4, 3};
    tbl[7]  = '{1'b1, 1'b0, 1, 0, 4, 1};
    tbl[8]  = '{1'b1, 1'b1, 1, 0, 3, 3};
    tbl[9]  = '{1'b0, 1'b0, 1, 0, 2, 1};
    tbl[10] = '{1'b0, 1'b0, 1, 0, 2, 1};

    defaults();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      retire  = tbl[i].retire;
      ic_busy = tbl[i].ic_busy;
      #2;
      chk($sformatf("tbl%0d.sel", i), int'(sel_d), tbl[i].sel);
      chk($sformatf("tbl%0d.switch", i), int'(sw_d), tbl[i].sw);
      chk($sformatf("tbl%0d.quantum", i), int'(q_d), tbl[i].quan);
      chk($sformatf("tbl%0d.busy", i), int'(busy_d), tbl[i].busy);
      cycle();
    end

    // Hart 1 asleep: expiry on hart 0 lands on hart 2, then hart 2 sleeps -> hart 3
    defaults(); run_a = 4'b1101; retire = 1'b1;
    do_reset();
    seen = 1'b0; cyc = 0;
    for (int i = 0; i < 12 && !seen; i++) begin cycle(); cyc++; if (sw_a) seen = 1'b1; end
    chk("skip_expiry_seen", int'(seen), 1);
    chk("skip_expiry_cycles", cyc, 6);
    chk("skip_expiry_sel", int'(sel_a), 2);
    run_a = 4'b1001;
    seen = 1'b0; cyc = 0;
    for (int i = 0; i < 8 && !seen; i++) begin cycle(); cyc++; if (sw_a) seen = 1'b1; end
    chk("wfi_drop_seen", int'(seen), 1);
    chk("wfi_drop_cycles", cyc, 3);
    chk("wfi_drop_sel", int'(sel_a), 3);

    // Interrupt on hart 2 preempts hart 0 (a) but not without preemption (b)
    defaults();
    do_reset();
    retire = 1'b1; cycle();
    retire = 1'b0; irq_a = 4'b0100; irq_b = 3'b100;
    tick(2);
    chk("irq_preempt_sel", int'(sel_a), 2);
    chk("irq_preempt_switch", int'(sw_a), 1);
    chk("irq_nopreempt_sel", int'(sel_b), 0);
    retire = 1'b1; tick(3);
    chk("irq_nopreempt_hold_sel", int'(sel_b), 0);
    chk("irq_nopreempt_expired", int'(q_b), 0);
    tick(2);
    chk("irq_nopreempt_expiry_sel", int'(sel_b), 1);
    chk("irq_nopreempt_expiry_switch", int'(sw_b), 1);

    // Long drain: everyone stalled, and hold keeps the arbiter in drain
    defaults(); drained = 1'b0; retire = 1'b1;
    do_reset();
    tick(5);
    for (int i = 0; i < 10; i++) begin
      chk("drain_wait_busy", int'(busy_a), 15);
      chk("drain_wait_switch", int'(sw_a), 0);
      chk("drain_wait_sel", int'(sel_a), 0);
      cycle();
    end
    hold = 1'b1; drained = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("drain_hold_busy", int'(busy_a), 15);
      chk("drain_hold_switch", int'(sw_a), 0);
    end
    hold = 1'b0; cycle();
    chk("drain_done_switch", int'(sw_a), 1);
    chk("drain_done_sel", int'(sel_a), 1);

    // Hold in RUN prevents the handover from starting
    defaults(); hold = 1'b1; retire = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("run_hold_busy", int'(busy_a), 14);
      chk("run_hold_sel", int'(sel_a), 0);
    end
    chk("run_hold_quantum", int'(q_a), 0);
    hold = 1'b0; tick(2);
    chk("run_hold_release_switch", int'(sw_a), 1);
    chk("run_hold_release_sel", int'(sel_a), 1);

    // Reset in the middle of a drain toward hart 3
    defaults(); run_a = 4'b1001; drained = 1'b0; retire = 1'b1;
    do_reset();
    tick(5);
    chk("mid_drain_busy", int'(busy_a), 15);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_sel", int'(sel_a), 0);
    chk("async_rst_oh", int'(oh_a), 1);
    chk("async_rst_switch", int'(sw_a), 0);
    chk("async_rst_quantum", int'(q_a), 4);
    chk("async_rst_busy", int'(busy_a), 14);
    reset_models();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    #1;
    RST = 1'b0; drained = 1'b1;
    chk("post_rst_quantum", int'(q_a), 4);
    chk("post_rst_sel", int'(sel_a), 0);
    tick(2);
    chk("post_rst_run_sel", int'(sel_a), 0);
    chk("post_rst_run_quantum", int'(q_a), 2);

    // Randomized traffic on all four configurations
    defaults();
    do_reset();
    any_sw_c = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      retire  = ($urandom_range(0, 3) != 0);
      hold    = ($urandom_range(0, 9) == 0);
      safe    = ($urandom_range(0, 9) < 7);
      drained = ($urandom_range(0, 9) < 6);
      ic_busy = $urandom_range(0, 1) == 1;
      for (int b = 0; b < 4; b++) rv[b] = ($urandom_range(0, 9) < 8);
      run_a = rv; run_b = rv[2:0]; run_c = rv[0:0]; run_d = rv[3:2];
      for (int b = 0; b < 4; b++) rv[b] = ($urandom_range(0, 19) < 3);
      irq_a = rv; irq_b = rv[3:1]; irq_c = rv[1:1]; irq_d = rv[1:0];
      cycle();
      if (sw_c) any_sw_c = 1'b1;
    end
    chk("single_hart_never_switch", int'(any_sw_c), 0);
    chk("single_hart_saturated", int'(q_c), 0);
    chk("single_hart_sel", int'(sel_c), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, checks=%0d errors=%0d", nchk, nerr);
    $fatal(1);
  end

endmodule
